// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory port: RV32 width codes,
// FSM states, request legality and store byte-lane mask generation.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_e;

  // Legal width code for the direction; unsigned widths only make sense for loads.
  function automatic logic f3_legal(input logic [2:0] funct3, input logic we);
    logic ok_v;
    case (funct3)
      F3_B, F3_H, F3_W: ok_v = 1'b1;
      F3_BU, F3_HU:     ok_v = ~we;
      default:          ok_v = 1'b0;
    endcase
    return ok_v;
  endfunction

  // Byte-lane write mask for a store of the given width at byte offset off.
  function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] mask_v;
    case (funct3)
      F3_B:    mask_v = 4'b0001 << off;
      F3_H:    mask_v = 4'b0011 << off;
      F3_W:    mask_v = 4'b1111;
      default: mask_v = 4'b0000;
    endcase
    return mask_v;
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Request/response handshake between the execute stage (master) and the
// load/store memory port (slave).
interface lsu_mem_port_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_load_align.sv
// Formats a raw memory word into RV32 load data: shifts the addressed byte or
// halfword down to bit 0 and sign- or zero-extends. Purely combinational so the
// writeback path can reuse it.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted_s;

  // Shift the addressed lane to bit 0, then extend according to the width code.
  always_comb begin
    shifted_s = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    data = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    data = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    data = shifted_s;
      F3_BU:   data = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
      F3_HU:   data = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
      default: data = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator: takes one byte-addressed RV32 load/store per handshake,
// runs a single access on the word-addressed, byte-masked data memory and
// returns a one-cycle response pulse. Bad requests skip the memory entirely.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int XLEN   = 32
) (
  input  logic             clk,
  input  logic             rst,
  lsu_mem_port_if.slave    bus,
  output logic [XLEN-1:0]  mem_addrL,
  output logic [XLEN-1:0]  mem_addrS,
  output logic [XLEN-1:0]  mem_data_wr,
  input  logic [XLEN-1:0]  mem_data_rd,
  output logic             mem_wr,
  output logic             mem_cs,
  output logic [3:0]       mem_mask
);

  state_e          state_r, state_s;
  logic            accept_s, req_err_s, misalign_s, range_err_s;

  // Fields of the accepted request still needed after the accept edge.
  logic            we_r;
  logic [2:0]      funct3_r;
  logic [1:0]      off_r;

  logic [XLEN-1:0] load_data_s;

  // Registered outputs and their next values.
  logic            req_ready_r, req_ready_s;
  logic            resp_valid_r, resp_valid_s;
  logic            resp_err_r, resp_err_s;
  logic [XLEN-1:0] resp_rdata_r, resp_rdata_s;
  logic            mem_cs_r, mem_cs_s;
  logic            mem_wr_r, mem_wr_s;
  logic [3:0]      mem_mask_r, mem_mask_s;
  logic [XLEN-1:0] mem_addr_r, mem_addr_s;
  logic [XLEN-1:0] mem_data_wr_r, mem_data_wr_s;

  // Replicate store data across every lane so the mask alone selects bytes.
  function automatic logic [XLEN-1:0] lane_rep(input logic [2:0] funct3, input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] rep_v;
    case (funct3)
      F3_B:    rep_v = {(XLEN/8){wd[7:0]}};
      F3_H:    rep_v = {(XLEN/16){wd[15:0]}};
      default: rep_v = wd;
    endcase
    return rep_v;
  endfunction

  assign accept_s = (state_r == S_IDLE) && bus.req_valid;

  // Classify the live request: illegal width code, misalignment or word index past the memory.
  always_comb begin
    misalign_s = 1'b0;
    case (bus.req_funct3)
      F3_H, F3_HU: misalign_s = bus.req_addr[0];
      F3_W:        misalign_s = (bus.req_addr[1:0] != 2'b00);
      default:     misalign_s = 1'b0;
    endcase
    range_err_s = |bus.req_addr[XLEN-1:ADDR_W+2];
    req_err_s   = ~f3_legal(bus.req_funct3, bus.req_we) | misalign_s | range_err_s;
  end

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (mem_data_rd),
    .off    (off_r),
    .funct3 (funct3_r),
    .data   (load_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: errors bypass the memory access and respond directly.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (req_err_s) begin
            state_s = S_RESP;
          end else begin
            state_s = S_ACCESS;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ACCESS: state_s = S_RESP;
      S_RESP:   state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // Output decode: next values of every registered output, memory idle unless entering ACCESS.
  always_comb begin
    req_ready_s   = (state_s == S_IDLE);
    resp_valid_s  = (state_s == S_RESP);
    resp_err_s    = resp_err_r;
    resp_rdata_s  = resp_rdata_r;
    mem_cs_s      = 1'b1;
    mem_wr_s      = 1'b0;
    mem_mask_s    = 4'b0000;
    mem_addr_s    = {XLEN{1'b0}};
    mem_data_wr_s = {XLEN{1'b0}};
    case (state_r)
      S_IDLE: begin
        if (accept_s && req_err_s) begin
          resp_err_s   = 1'b1;
          resp_rdata_s = {XLEN{1'b0}};
        end else if (accept_s) begin
          resp_err_s   = 1'b0;
          resp_rdata_s = {XLEN{1'b0}};
          mem_cs_s     = 1'b0;
          mem_wr_s     = bus.req_we;
          mem_addr_s   = {{(XLEN-ADDR_W){1'b0}}, bus.req_addr[ADDR_W+1:2]};
          if (bus.req_we) begin
            mem_mask_s    = store_mask(bus.req_funct3, bus.req_addr[1:0]);
            mem_data_wr_s = lane_rep(bus.req_funct3, bus.req_wdata);
          end else begin
            mem_mask_s    = 4'b0000;
            mem_data_wr_s = {XLEN{1'b0}};
          end
        end else begin
          resp_err_s   = resp_err_r;
          resp_rdata_s = resp_rdata_r;
        end
      end
      S_ACCESS: begin
        resp_err_s = 1'b0;
        if (we_r) begin
          resp_rdata_s = {XLEN{1'b0}};
        end else begin
          resp_rdata_s = load_data_s;
        end
      end
      S_RESP: begin
        resp_err_s   = resp_err_r;
        resp_rdata_s = resp_rdata_r;
      end
      default: begin
        resp_err_s   = resp_err_r;
        resp_rdata_s = resp_rdata_r;
      end
    endcase
  end

  // Output registers; reset forces the memory back to deselected immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_r   <= 1'b1;
      resp_valid_r  <= 1'b0;
      resp_err_r    <= 1'b0;
      resp_rdata_r  <= {XLEN{1'b0}};
      mem_cs_r      <= 1'b1;
      mem_wr_r      <= 1'b0;
      mem_mask_r    <= 4'b0000;
      mem_addr_r    <= {XLEN{1'b0}};
      mem_data_wr_r <= {XLEN{1'b0}};
    end else begin
      req_ready_r   <= req_ready_s;
      resp_valid_r  <= resp_valid_s;
      resp_err_r    <= resp_err_s;
      resp_rdata_r  <= resp_rdata_s;
      mem_cs_r      <= mem_cs_s;
      mem_wr_r      <= mem_wr_s;
      mem_mask_r    <= mem_mask_s;
      mem_addr_r    <= mem_addr_s;
      mem_data_wr_r <= mem_data_wr_s;
    end
  end

  // Capture the fields the load formatter needs; inputs are only sampled on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r     <= 1'b0;
      funct3_r <= 3'b000;
      off_r    <= 2'b00;
    end else if (accept_s) begin
      we_r     <= bus.req_we;
      funct3_r <= bus.req_funct3;
      off_r    <= bus.req_addr[1:0];
    end else begin
      we_r     <= we_r;
      funct3_r <= funct3_r;
      off_r    <= off_r;
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign mem_cs         = mem_cs_r;
  assign mem_wr         = mem_wr_r;
  assign mem_mask       = mem_mask_r;
  assign mem_addrL      = mem_addr_r;
  assign mem_addrS      = mem_addr_r;
  assign mem_data_wr    = mem_data_wr_r;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: requests push expected responses and
// memory accesses into queues computed from a byte-array reference memory;
// independent monitors pop and compare on every response pulse / chip select.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addrL, mem_addrS, mem_data_wr, mem_data_rd;
  logic        mem_wr, mem_cs;
  logic [3:0]  mem_mask;

  lsu_mem_port_if #(.XLEN(32)) bus ();

  lsu_mem_port #(.ADDR_W(8), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mem_addrL   (mem_addrL),
    .mem_addrS   (mem_addrS),
    .mem_data_wr (mem_data_wr),
    .mem_data_rd (mem_data_rd),
    .mem_wr      (mem_wr),
    .mem_cs      (mem_cs),
    .mem_mask    (mem_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] widx;
    logic [3:0]  mask;
    logic [31:0] data;
  } acc_t;

  resp_t resp_q[$];
  acc_t  acc_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_c = -1;
  bit last_err = 1'b0;

  logic [31:0] mem_arr [0:255];
  logic [7:0]  ref_mem [0:1023];

  // Data memory: combinational read, masked write on the falling edge.
  assign mem_data_rd = (mem_addrL < 32'd256) ? mem_arr[mem_addrL[7:0]] : 32'h0;
  always @(negedge clk) begin
    if (!mem_cs && mem_wr) begin
      for (int k = 0; k < 4; k++)
        if (mem_mask[k]) mem_arr[mem_addrS[7:0]][8*k +: 8] <= mem_data_wr[8*k +: 8];
    end
  end

  // Cycle counter used for latency expectations.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Response and memory-access monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_latency", cyc, e.cyc);
        end
      end
      if (!mem_cs) begin
        if (acc_q.size() == 0) begin
          chk("access_unexpected", 32'd1, 32'd0);
        end else begin
          acc_t a;
          a = acc_q.pop_front();
          chk("mem_wr", {31'd0, mem_wr}, {31'd0, a.we});
          chk("mem_addrL", mem_addrL, a.widx);
          chk("mem_addrS", mem_addrS, a.widx);
          chk("mem_mask", {28'd0, mem_mask}, {28'd0, a.mask});
          if (a.we) chk("mem_data_wr", mem_data_wr, a.data);
        end
      end else begin
        chk("idle_mem_wr_mask", {27'd0, mem_wr, mem_mask}, 32'd0);
      end
    end
  end

  // Drive one request at a falling edge, predict its effect, and walk it through the busy cycles.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit hold);
    int    wc;
    int    size;
    bit    err;
    logic [31:0] v;
    resp_t r;
    acc_t  a;
    wc = 0;
    while (!bus.req_ready && wc < 10) begin
      @(negedge clk);
      wc++;
    end
    chk("ready_wait", {31'd0, bus.req_ready}, 32'd1);
    if (last_c >= 0) chk("accept_spacing", cyc - last_c, last_err ? 32'd2 : 32'd3);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    err = (size == 0) || (we && f3[2]) || (addr >= 32'd1024);
    if (!err) err = (addr % size) != 0;
    v = 32'h0;
    if (!err && we) begin
      for (int i = 0; i < size; i++) ref_mem[addr + i] = wd[8*i +: 8];
    end else if (!err) begin
      for (int i = 0; i < size; i++) v = v | ({24'h0, ref_mem[addr + i]} << (8*i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
    end
    r.err = err; r.rdata = v; r.cyc = cyc + (err ? 1 : 2);
    resp_q.push_back(r);
    if (!err) begin
      a.we = we; a.widx = addr >> 2; a.mask = 4'b0000; a.data = 32'h0;
      for (int k = 0; k < 4; k++) a.data[8*k +: 8] = wd[8*(k % size) +: 8];
      if (we) for (int i = 0; i < size; i++) a.mask[(addr % 4) + i] = 1'b1;
      acc_q.push_back(a);
    end
    last_c = cyc; last_err = err;
    for (int b = 0; b < (err ? 1 : 2); b++) begin
      @(negedge clk);
      chk("busy_ready", {31'd0, bus.req_ready}, 32'd0);
      bus.req_valid = hold;
      bus.req_we = 1'($urandom_range(0, 1)); bus.req_funct3 = 3'($urandom_range(0, 7));
      bus.req_addr = $urandom; bus.req_wdata = $urandom;
    end
    @(negedge clk);
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    int sel, size;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    for (int w = 0; w < 256; w++) begin
      mem_arr[w] = $urandom;
      for (int k = 0; k < 4; k++) ref_mem[4*w + k] = mem_arr[w][8*k +: 8];
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_cs", {31'd0, mem_cs}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset_resp", {30'd0, bus.resp_valid, bus.resp_err}, 32'd0);
    chk("reset_rdata", bus.resp_rdata, 32'd0);
    chk("reset_cs_wr", {30'd0, mem_cs, mem_wr}, 32'd2);
    chk("reset_mask", {28'd0, mem_mask}, 32'd0);
    chk("reset_addr", mem_addrL | mem_addrS | mem_data_wr, 32'd0);

    // Directed sequence: word/byte/half stores and loads, then error requests.
    issue(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 3'b010, 32'h8, 32'h0, 1'b0);
    issue(1'b1, 3'b000, 32'h9, 32'h000000AA, 1'b0);
    issue(1'b0, 3'b010, 32'h8, 32'h0, 1'b0);
    issue(1'b0, 3'b000, 32'h9, 32'h0, 1'b0);
    issue(1'b0, 3'b100, 32'h9, 32'h0, 1'b0);
    issue(1'b0, 3'b001, 32'hA, 32'h0, 1'b0);
    issue(1'b0, 3'b101, 32'hA, 32'h0, 1'b0);
    issue(1'b1, 3'b001, 32'hA, 32'h00001234, 1'b0);
    issue(1'b0, 3'b010, 32'h8, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'h6, 32'h0, 1'b0);
    issue(1'b1, 3'b001, 32'h3, 32'h5555, 1'b0);
    issue(1'b0, 3'b011, 32'h0, 32'h0, 1'b0);
    issue(1'b1, 3'b100, 32'h0, 32'h77, 1'b0);
    issue(1'b0, 3'b010, 32'h400, 32'h0, 1'b0);
    // Back-to-back loads with valid held high and inputs scrambled while busy.
    issue(1'b0, 3'b010, 32'h8, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'hC, 32'h0, 1'b1);
    bus.req_valid = 1'b0;
    @(negedge clk);
    last_c = -1;

    // Reset during the ACCESS cycle of a store, before its falling edge.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h12345678;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_cs", {31'd0, mem_cs}, 32'd1);
    chk("midrst_resp", {31'd0, bus.resp_valid}, 32'd0);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, bus.req_ready}, 32'd1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);

    // Randomized traffic, biased toward legal in-range requests.
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 19);
      case ($urandom_range(0, 6))
        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
        3: f3 = 3'b100; 4: f3 = 3'b101; 5: f3 = 3'b010;
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
      addr = 32'($urandom_range(0, 1023));
      if (sel < 15) addr = addr & ~(32'(size) - 32'd1);
      else if (sel == 18) addr = $urandom;
      else if (sel == 19) addr = 32'h400 + 32'($urandom_range(0, 15));
      issue(1'($urandom_range(0, 1)), f3, addr, $urandom, 1'($urandom_range(0, 1)));
    end
    bus.req_valid = 1'b0;

    for (int d = 0; d < 10 && (resp_q.size() != 0 || acc_q.size() != 0); d++) @(negedge clk);
    chk("drain_resp", resp_q.size(), 32'd0);
    chk("drain_acc", acc_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
